// File: rtl/y86_seq_controller.sv
// ---------------------------------------------------------------------------
// y86_seq_controller
//
// Multi-cycle sequencer for the sequential Y86-64 core. Walks each
// instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE,
// one stage per state. It also owns the condition codes (ZF/SF/OF), evaluates
// jXX/cmovXX conditions, handshakes with data memory and tracks status.
//
// Every output is a Moore function of registered state. icode/ifun are
// captured when the fetch is accepted, so the outputs have no combinational
// path from any input.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   pulse: leave IDLE and begin fetching
//   i_instr_valid             fetch unit has icode/ifun ready
//   i_imem_error              fetch address invalid (sampled with valid)
//   i_icode, i_ifun           current instruction and function codes
//   i_alu_zf/sf/of            raw ALU flags for the current OPq result
//   i_mem_ack, i_dmem_error   data memory done / address invalid
//   o_fetch_en .. o_pc_en     stage enables, high for the whole state
//   o_mem_req, o_mem_wr       data memory request and write qualifier
//   o_wb_en                   register-file write strobe
//   o_zf, o_sf, o_of          architectural condition codes
//   o_cnd                     registered condition result
//   o_stat                    1=AOK 2=HLT 3=ADR 4=INS
//   o_instr_count             retired instructions, wraps to 0
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start
// FETCH      | waiting for instr_valid; checks fetch error and legality
// DECODE     | register read, one cycle
// EXECUTE    | ALU; CC and cnd update on exit
// MEMORY     | data memory handshake with timeout, or one idle cycle
// WRITEBACK  | register-file write
// PCUPDATE   | PC write; retires the instruction
// HALT       | terminal after halt, only reset leaves
// ERR        | terminal after ADR/INS fault, only reset leaves
// ---------------------------------------------------------------------------
module y86_seq_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_instr_valid,
    input  logic             i_imem_error,
    input  logic [3:0]       i_icode,
    input  logic [3:0]       i_ifun,
    input  logic             i_alu_zf,
    input  logic             i_alu_sf,
    input  logic             i_alu_of,
    input  logic             i_mem_ack,
    input  logic             i_dmem_error,
    output logic             o_fetch_en,
    output logic             o_decode_en,
    output logic             o_exec_en,
    output logic             o_pc_en,
    output logic             o_mem_req,
    output logic             o_mem_wr,
    output logic             o_wb_en,
    output logic             o_zf,
    output logic             o_sf,
    output logic             o_of,
    output logic             o_cnd,
    output logic [2:0]       o_stat,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int             TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPDATE,
        S_HALT,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [3:0]       r_icode;
    logic [3:0]       r_ifun;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;
    logic             r_cnd;
    logic [2:0]       r_stat;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_tmr;

    logic             w_illegal;
    logic             w_is_mem;
    logic             w_is_wr;
    logic             w_wb_always;
    logic             w_latch;
    logic             w_cc_upd;
    logic             w_cnd_upd;
    logic             w_cnt_inc;
    logic             w_stat_set;
    logic [2:0]       w_stat_val;
    logic             w_tmr_load;
    logic             w_tmr_dec;

    function automatic logic f_cond(input logic [3:0] fn, input logic zf,
                                    input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (fn)
            4'd0:    f_cond = 1'b1;
            4'd1:    f_cond = lt | zf;
            4'd2:    f_cond = lt;
            4'd3:    f_cond = zf;
            4'd4:    f_cond = ~zf;
            4'd5:    f_cond = ~lt;
            4'd6:    f_cond = ~lt & ~zf;
            default: f_cond = 1'b0;
        endcase
    endfunction

    // Legality is judged on the live fetch bus; everything later uses the
    // captured copy.
    assign w_illegal = (i_icode > 4'hB) ||
                       (((i_icode == 4'h2) || (i_icode == 4'h7)) && (i_ifun > 4'd6)) ||
                       ((i_icode == 4'h6) && (i_ifun > 4'd3));

    assign w_is_mem    = (r_icode == 4'h4) || (r_icode == 4'h5) || (r_icode == 4'h8) ||
                         (r_icode == 4'h9) || (r_icode == 4'hA) || (r_icode == 4'hB);
    assign w_is_wr     = (r_icode == 4'h4) || (r_icode == 4'h8) || (r_icode == 4'hA);
    assign w_wb_always = (r_icode == 4'h3) || (r_icode == 4'h5) || (r_icode == 4'h6) ||
                         (r_icode == 4'h8) || (r_icode == 4'h9) || (r_icode == 4'hA) ||
                         (r_icode == 4'hB);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_fetch_en   = 1'b0;
        o_decode_en  = 1'b0;
        o_exec_en    = 1'b0;
        o_pc_en      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_wr     = 1'b0;
        o_wb_en      = 1'b0;
        w_latch      = 1'b0;
        w_cc_upd     = 1'b0;
        w_cnd_upd    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_stat_set   = 1'b0;
        w_stat_val   = STAT_AOK;
        w_tmr_load   = 1'b0;
        w_tmr_dec    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                o_fetch_en = 1'b1;
                if (i_instr_valid) begin
                    if (i_imem_error) begin
                        w_next_state = S_ERR;
                        w_stat_set   = 1'b1;
                        w_stat_val   = STAT_ADR;
                    end else if (w_illegal) begin
                        w_next_state = S_ERR;
                        w_stat_set   = 1'b1;
                        w_stat_val   = STAT_INS;
                    end else begin
                        w_next_state = S_DECODE;
                        w_latch      = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                o_decode_en  = 1'b1;
                w_next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                o_exec_en    = 1'b1;
                w_next_state = S_MEMORY;
                w_cc_upd     = (r_icode == 4'h6);
                w_cnd_upd    = (r_icode == 4'h2) || (r_icode == 4'h7);
                w_tmr_load   = 1'b1;
            end
            S_MEMORY: begin
                if (w_is_mem) begin
                    o_mem_req = 1'b1;
                    o_mem_wr  = w_is_wr;
                    // An ack on the last allowed cycle still wins over timeout.
                    if (i_mem_ack) begin
                        if (i_dmem_error) begin
                            w_next_state = S_ERR;
                            w_stat_set   = 1'b1;
                            w_stat_val   = STAT_ADR;
                        end else begin
                            w_next_state = S_WRITEBACK;
                        end
                    end else if (r_tmr == '0) begin
                        w_next_state = S_ERR;
                        w_stat_set   = 1'b1;
                        w_stat_val   = STAT_ADR;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                o_wb_en      = w_wb_always || ((r_icode == 4'h2) && r_cnd);
                w_next_state = S_PCUPDATE;
            end
            S_PCUPDATE: begin
                o_pc_en   = 1'b1;
                w_cnt_inc = 1'b1;
                if (r_icode == 4'h0) begin
                    w_next_state = S_HALT;
                    w_stat_set   = 1'b1;
                    w_stat_val   = STAT_HLT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            S_ERR: begin
                w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_icode <= 4'h0;
            r_ifun  <= 4'h0;
            r_zf    <= 1'b1;
            r_sf    <= 1'b0;
            r_of    <= 1'b0;
            r_cnd   <= 1'b0;
            r_stat  <= STAT_AOK;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else begin
            if (w_latch) begin
                r_icode <= i_icode;
                r_ifun  <= i_ifun;
            end
            if (w_cc_upd) begin
                r_zf <= i_alu_zf;
                r_sf <= i_alu_sf;
                r_of <= i_alu_of;
            end
            // Condition uses the CC as it stood before this edge.
            if (w_cnd_upd) begin
                r_cnd <= f_cond(r_ifun, r_zf, r_sf, r_of);
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_stat_set) begin
                r_stat <= w_stat_val;
            end
            if (w_tmr_load) begin
                r_tmr <= TMR_LOAD;
            end else if (w_tmr_dec) begin
                r_tmr <= r_tmr - TMR_W'(1);
            end
        end
    end

    assign o_zf          = r_zf;
    assign o_sf          = r_sf;
    assign o_of          = r_of;
    assign o_cnd         = r_cnd;
    assign o_stat        = r_stat;
    assign o_instr_count = r_cnt;

endmodule

// File: tb/tb_y86_seq_controller.sv
module tb_y86_seq_controller;

    localparam int CW  = 4;
    localparam int TMO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_instr_valid = 1'b0;
    logic          i_imem_error = 1'b0;
    logic [3:0]    i_icode = 4'h0;
    logic [3:0]    i_ifun = 4'h0;
    logic          i_alu_zf = 1'b0;
    logic          i_alu_sf = 1'b0;
    logic          i_alu_of = 1'b0;
    logic          i_mem_ack = 1'b0;
    logic          i_dmem_error = 1'b0;
    logic          o_fetch_en, o_decode_en, o_exec_en, o_pc_en;
    logic          o_mem_req, o_mem_wr, o_wb_en;
    logic          o_zf, o_sf, o_of, o_cnd;
    logic [2:0]    o_stat;
    logic [CW-1:0] o_instr_count;

    y86_seq_controller #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_instr_valid(i_instr_valid), .i_imem_error(i_imem_error),
        .i_icode(i_icode), .i_ifun(i_ifun),
        .i_alu_zf(i_alu_zf), .i_alu_sf(i_alu_sf), .i_alu_of(i_alu_of),
        .i_mem_ack(i_mem_ack), .i_dmem_error(i_dmem_error),
        .o_fetch_en(o_fetch_en), .o_decode_en(o_decode_en), .o_exec_en(o_exec_en),
        .o_pc_en(o_pc_en), .o_mem_req(o_mem_req), .o_mem_wr(o_mem_wr),
        .o_wb_en(o_wb_en), .o_zf(o_zf), .o_sf(o_sf), .o_of(o_of), .o_cnd(o_cnd),
        .o_stat(o_stat), .o_instr_count(o_instr_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int fetch, dec, exe, mreq, mwr, wb, pc, cyc;
    } meas_t;

    typedef struct {
        logic [3:0] ic, fn;
        logic [2:0] alu;
        int         vdly, adly;
        int         e_cyc, e_mreq, e_mwr, e_wb;
        logic [2:0] e_cc;
        logic       e_cnd;
        logic [2:0] e_stat;
    } vec_t;

    int    n_pass = 0;
    int    n_tot  = 0;
    meas_t ob;
    logic  ob_timeout;

    // reference model state
    logic       md_zf, md_sf, md_of, md_cnd;
    logic [2:0] md_stat;
    int         md_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk($sformatf("%s enables", tag),
            32'({o_fetch_en, o_decode_en, o_exec_en, o_pc_en, o_mem_req, o_mem_wr, o_wb_en}), 0);
        chk($sformatf("%s cc", tag), 32'({o_zf, o_sf, o_of}), 32'h4);
        chk($sformatf("%s cnd", tag), 32'(o_cnd), 0);
        chk($sformatf("%s stat", tag), 32'(o_stat), 1);
        chk($sformatf("%s count", tag), 32'(o_instr_count), 0);
    endtask

    task automatic reset_dut();
        i_rst_n = 1'b0; i_start = 1'b0; i_instr_valid = 1'b0; i_imem_error = 1'b0;
        i_mem_ack = 1'b0; i_dmem_error = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic start_dut();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge after
    // the instruction retires or faults. Reacts to the DUT's handshakes only.
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] alu,
                             input int vdly, input int adly, input logic ierr, input logic derr);
        int fc, mc, g;
        logic seen_pc;
        fc = 0; mc = 0; g = 0; seen_pc = 1'b0; ob_timeout = 1'b0;
        ob = '{default: 0};
        i_icode = ic; i_ifun = fn;
        {i_alu_zf, i_alu_sf, i_alu_of} = alu;
        while (1) begin
            if (seen_pc || (o_stat !== 3'd1)) break;
            if (g >= 100) begin ob_timeout = 1'b1; break; end
            ob.cyc++;
            if (o_fetch_en)  ob.fetch++;
            if (o_decode_en) ob.dec++;
            if (o_exec_en)   ob.exe++;
            if (o_mem_req)   ob.mreq++;
            if (o_mem_wr)    ob.mwr++;
            if (o_wb_en)     ob.wb++;
            if (o_pc_en)     begin ob.pc++; seen_pc = 1'b1; end
            i_instr_valid = o_fetch_en && (fc >= vdly);
            i_imem_error  = ierr;
            i_mem_ack     = o_mem_req && (mc >= adly);
            i_dmem_error  = derr;
            if (o_fetch_en) fc++;
            if (o_mem_req)  mc++;
            @(negedge i_clk);
            g++;
        end
        i_instr_valid = 1'b0; i_imem_error = 1'b0; i_mem_ack = 1'b0; i_dmem_error = 1'b0;
    endtask

    task automatic compare_all(input string tag, input meas_t e, input logic [2:0] ecc,
                               input logic ecnd, input logic [2:0] estat, input int ecnt);
        chk($sformatf("%s finished", tag), 32'(ob_timeout), 0);
        chk($sformatf("%s cycles", tag), ob.cyc, e.cyc);
        chk($sformatf("%s fetch", tag), ob.fetch, e.fetch);
        chk($sformatf("%s decode", tag), ob.dec, e.dec);
        chk($sformatf("%s exec", tag), ob.exe, e.exe);
        chk($sformatf("%s mem_req", tag), ob.mreq, e.mreq);
        chk($sformatf("%s mem_wr", tag), ob.mwr, e.mwr);
        chk($sformatf("%s wb_en", tag), ob.wb, e.wb);
        chk($sformatf("%s pc_en", tag), ob.pc, e.pc);
        chk($sformatf("%s cc", tag), 32'({o_zf, o_sf, o_of}), 32'(ecc));
        chk($sformatf("%s cnd", tag), 32'(o_cnd), 32'(ecnd));
        chk($sformatf("%s stat", tag), 32'(o_stat), 32'(estat));
        chk($sformatf("%s count", tag), 32'(o_instr_count), ecnt);
    endtask

    task automatic check_frozen(input string tag, input logic [2:0] es, input int ecnt,
                                input logic [2:0] ecc, input logic ecnd);
        for (int c = 0; c < 4; c++) begin
            i_start = 1'b1; i_mem_ack = 1'b1; i_instr_valid = 1'b1;
            {i_alu_zf, i_alu_sf, i_alu_of} = 3'(c + 3);
            @(negedge i_clk);
            chk($sformatf("%s frozen enables", tag),
                32'({o_fetch_en, o_decode_en, o_exec_en, o_pc_en, o_mem_req, o_mem_wr, o_wb_en}), 0);
        end
        i_start = 1'b0; i_mem_ack = 1'b0; i_instr_valid = 1'b0;
        chk($sformatf("%s frozen stat", tag), 32'(o_stat), 32'(es));
        chk($sformatf("%s frozen count", tag), 32'(o_instr_count), ecnt);
        chk($sformatf("%s frozen cc", tag), 32'({o_zf, o_sf, o_of}), 32'(ecc));
        chk($sformatf("%s frozen cnd", tag), 32'(o_cnd), 32'(ecnd));
    endtask

    task automatic model_reset();
        md_zf = 1'b1; md_sf = 1'b0; md_of = 1'b0; md_cnd = 1'b0;
        md_stat = 3'd1; md_cnt = 0;
    endtask

    // Architectural effect of one instruction plus the cycle budget of each stage.
    task automatic model_step(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] alu,
                              input int vdly, input int adly, input logic ierr, input logic derr,
                              output meas_t e);
        logic       illegal, is_mem, is_wr, less, equal;
        logic [6:0] conds;
        e = '{default: 0};
        e.fetch = vdly + 1;
        e.cyc   = e.fetch;
        illegal = (ic > 11) || ((ic == 2 || ic == 7) && fn > 6) || (ic == 6 && fn > 3);
        if (ierr)    begin md_stat = 3'd3; return; end
        if (illegal) begin md_stat = 3'd4; return; end
        e.dec = 1; e.exe = 1; e.cyc += 2;
        less  = (md_sf != md_of);
        equal = md_zf;
        conds = {!less && !equal, !less, !equal, equal, less, less || equal, 1'b1};
        if (ic == 2 || ic == 7) md_cnd = conds[fn[2:0]];
        if (ic == 6) {md_zf, md_sf, md_of} = alu;
        is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        is_wr  = ic inside {4'h4, 4'h8, 4'hA};
        if (is_mem) begin
            e.mreq = (adly < TMO) ? adly + 1 : TMO;
            e.mwr  = is_wr ? e.mreq : 0;
            e.cyc += e.mreq;
            if (adly >= TMO || derr) begin md_stat = 3'd3; return; end
        end else begin
            e.cyc += 1;
        end
        if (ic inside {4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) e.wb = 1;
        else if (ic == 2) e.wb = md_cnd ? 1 : 0;
        e.pc  = 1;
        e.cyc += 2;
        md_cnt = (md_cnt + 1) % (1 << CW);
        if (ic == 0) md_stat = 3'd2;
    endtask

    vec_t  tbl[13];
    meas_t e;

    initial begin
        //           ic    fn    alu     vd ad  cyc mrq mwr wb  cc      cnd   stat
        tbl[0]  = '{4'h6, 4'h1, 3'b010, 0, 0,  6,  0,  0,  1, 3'b010, 1'b0, 3'd1};
        tbl[1]  = '{4'h7, 4'h2, 3'b111, 0, 0,  6,  0,  0,  0, 3'b010, 1'b1, 3'd1};
        tbl[2]  = '{4'h7, 4'h6, 3'b000, 1, 0,  7,  0,  0,  0, 3'b010, 1'b0, 3'd1};
        tbl[3]  = '{4'h2, 4'h1, 3'b000, 0, 0,  6,  0,  0,  1, 3'b010, 1'b1, 3'd1};
        tbl[4]  = '{4'h3, 4'h0, 3'b000, 2, 0,  8,  0,  0,  1, 3'b010, 1'b1, 3'd1};
        tbl[5]  = '{4'h5, 4'h0, 3'b000, 0, 3,  9,  4,  0,  1, 3'b010, 1'b1, 3'd1};
        tbl[6]  = '{4'h4, 4'h0, 3'b000, 0, 0,  6,  1,  1,  0, 3'b010, 1'b1, 3'd1};
        tbl[7]  = '{4'h6, 4'h0, 3'b100, 0, 0,  6,  0,  0,  1, 3'b100, 1'b1, 3'd1};
        tbl[8]  = '{4'h7, 4'h3, 3'b011, 0, 0,  6,  0,  0,  0, 3'b100, 1'b1, 3'd1};
        tbl[9]  = '{4'h2, 4'h4, 3'b000, 0, 0,  6,  0,  0,  0, 3'b100, 1'b0, 3'd1};
        tbl[10] = '{4'hA, 4'h0, 3'b000, 0, 1,  7,  2,  2,  1, 3'b100, 1'b0, 3'd1};
        tbl[11] = '{4'h9, 4'h0, 3'b000, 0, 0,  6,  1,  0,  1, 3'b100, 1'b0, 3'd1};
        tbl[12] = '{4'h0, 4'h0, 3'b000, 0, 0,  6,  0,  0,  0, 3'b100, 1'b0, 3'd2};

        // reset values, then abort an in-flight memory request with reset
        @(negedge i_clk);
        #1 chk_reset("power-on");
        reset_dut();
        chk_reset("post-reset");
        start_dut();
        i_icode = 4'h5; i_ifun = 4'h0; i_instr_valid = 1'b1;
        for (int g = 0; g < 10 && !o_mem_req; g++) @(negedge i_clk);
        i_instr_valid = 1'b0;
        chk("reached MEMORY", 32'(o_mem_req), 1);
        i_rst_n = 1'b0;
        #1 chk_reset("async reset mid-MEMORY");
        @(negedge i_clk);
        chk_reset("held reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("stays IDLE without start", 32'(o_fetch_en), 0);

        // table program
        reset_dut();
        start_dut();
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].ic, tbl[i].fn, tbl[i].alu, tbl[i].vdly, tbl[i].adly, 1'b0, 1'b0);
            e = '{fetch: tbl[i].vdly + 1, dec: 1, exe: 1, mreq: tbl[i].e_mreq,
                  mwr: tbl[i].e_mwr, wb: tbl[i].e_wb, pc: 1, cyc: tbl[i].e_cyc};
            compare_all($sformatf("vec%0d", i), e, tbl[i].e_cc, tbl[i].e_cnd, tbl[i].e_stat, i + 1);
        end
        check_frozen("halt", 3'd2, 13, 3'b100, 1'b0);

        // irmovq then halt
        reset_dut(); start_dut();
        run_instr(4'h3, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);
        chk("irmovq cycles", ob.cyc, 6);
        chk("irmovq wb_en", ob.wb, 1);
        chk("irmovq mem_req", ob.mreq, 0);
        run_instr(4'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);
        chk("halt cycles", ob.cyc, 6);
        chk("halt wb_en", ob.wb, 0);
        chk("halt mem_req", ob.mreq, 0);
        chk("halt count", 32'(o_instr_count), 2);
        chk("halt stat", 32'(o_stat), 2);

        // pushq with no ack: timeout
        reset_dut(); start_dut();
        run_instr(4'hA, 4'h0, 3'b000, 0, 1000, 1'b0, 1'b0);
        chk("timeout mem_req cycles", ob.mreq, TMO);
        chk("timeout mem_wr cycles", ob.mwr, TMO);
        chk("timeout wb_en", ob.wb, 0);
        chk("timeout stat", 32'(o_stat), 3);
        check_frozen("timeout", 3'd3, 0, 3'b100, 1'b0);

        // ack on the last allowed cycle is accepted
        reset_dut(); start_dut();
        run_instr(4'hB, 4'h0, 3'b000, 0, TMO - 1, 1'b0, 1'b0);
        chk("late ack mem_req cycles", ob.mreq, TMO);
        chk("late ack stat", 32'(o_stat), 1);
        chk("late ack count", 32'(o_instr_count), 1);
        chk("late ack wb_en", ob.wb, 1);

        // dmem error
        reset_dut(); start_dut();
        run_instr(4'h5, 4'h0, 3'b000, 0, 1, 1'b0, 1'b1);
        chk("dmem err mem_req", ob.mreq, 2);
        chk("dmem err stat", 32'(o_stat), 3);
        chk("dmem err count", 32'(o_instr_count), 0);

        // fetch-stage faults
        reset_dut(); start_dut();
        run_instr(4'hC, 4'h0, 3'b111, 1, 0, 1'b0, 1'b0);
        chk("icode C cycles", ob.cyc, 2);
        chk("icode C stat", 32'(o_stat), 4);
        chk("icode C cc", 32'({o_zf, o_sf, o_of}), 32'h4);
        reset_dut(); start_dut();
        run_instr(4'h6, 4'h4, 3'b011, 0, 0, 1'b0, 1'b0);
        chk("OPq ifun4 exec", ob.exe, 0);
        chk("OPq ifun4 stat", 32'(o_stat), 4);
        chk("OPq ifun4 cc", 32'({o_zf, o_sf, o_of}), 32'h4);
        check_frozen("ins", 3'd4, 0, 3'b100, 1'b0);
        reset_dut(); start_dut();
        run_instr(4'h7, 4'h7, 3'b000, 0, 0, 1'b0, 1'b0);
        chk("jXX ifun7 stat", 32'(o_stat), 4);
        reset_dut(); start_dut();
        run_instr(4'h3, 4'h0, 3'b000, 0, 0, 1'b1, 1'b0);
        chk("imem err stat", 32'(o_stat), 3);
        chk("imem err decode", ob.dec, 0);

        // randomized programs against the reference model
        for (int p = 0; p < 6; p++) begin
            reset_dut(); start_dut(); model_reset();
            for (int k = 0; k < 40 && md_stat == 3'd1; k++) begin
                logic [3:0] ic, fn;
                logic [2:0] alu;
                int         vd, ad, r;
                logic       ie, de;
                r   = $urandom_range(0, 99);
                ic  = 4'($urandom_range(1, 11));
                fn  = 4'($urandom_range(0, 15));
                if (ic == 2 || ic == 7) fn = 4'($urandom_range(0, 6));
                if (ic == 6)            fn = 4'($urandom_range(0, 3));
                alu = 3'($urandom_range(0, 7));
                vd  = $urandom_range(0, 2);
                ad  = $urandom_range(0, 3);
                ie  = 1'b0; de = 1'b0;
                if (r < 2)       ie = 1'b1;
                else if (r < 4)  ic = 4'($urandom_range(12, 15));
                else if (r < 6)  de = 1'b1;
                else if (r < 8)  ad = TMO + 4;
                else if (r < 10) ic = 4'h0;
                model_step(ic, fn, alu, vd, ad, ie, de, e);
                run_instr(ic, fn, alu, vd, ad, ie, de);
                compare_all($sformatf("rnd p%0d i%0d ic%0h fn%0h", p, k, ic, fn), e,
                            {md_zf, md_sf, md_of}, md_cnd, md_stat, md_cnt);
            end
            if (md_stat != 3'd1)
                check_frozen($sformatf("rnd p%0d", p), md_stat, md_cnt, {md_zf, md_sf, md_of}, md_cnd);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
